// File: rtl/cpu_pkg.sv
// Shared types for the RV32I multi-cycle datapath: ALU op encoding,
// controller state encoding and the opcodes the controller decodes.
package cpu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_t;

  typedef enum logic [2:0] {
    CS_IDLE      = 3'd0,
    CS_FETCH     = 3'd1,
    CS_DECODE    = 3'd2,
    CS_EXECUTE   = 3'd3,
    CS_WRITEBACK = 3'd4,
    CS_HALT      = 3'd5
  } ctrl_state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle controller and the datapath.
// master = controller side (drives strobes), slave = datapath side.
interface multicycle_controller_if;
  import cpu_pkg::*;

  logic          start;
  logic [31:0]   instruction;
  logic          ir_write;
  logic          pc_write;
  logic          reg_write;
  logic          use_imm;
  alu_op_t       alu_op;
  logic          busy;
  logic          halted;
  logic          illegal;
  logic [31:0]   retired_count;
  logic [2:0]    state_check;

  modport master (
    input  start, instruction,
    output ir_write, pc_write, reg_write, use_imm, alu_op,
           busy, halted, illegal, retired_count, state_check
  );

  modport slave (
    output start, instruction,
    input  ir_write, pc_write, reg_write, use_imm, alu_op,
           busy, halted, illegal, retired_count, state_check
  );

endinterface

// File: rtl/multicycle_controller_decoder.sv
// Combinational RV32I decoder for the ALU subset: R-type and I-type
// arithmetic/logic ops; SLTU, SRA and their immediate forms are rejected.
module instruction_decoder
  import cpu_pkg::*;
(
  input  logic [31:0] instruction,
  output alu_op_t     alu_op,
  output logic        use_imm,
  output logic        legal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = instruction[6:0];
  assign funct3        = instruction[14:12];
  assign funct7        = instruction[31:25];
  assign unused_fields = ^{instruction[24:15], instruction[11:7]};

  always_comb begin
    alu_op  = ALU_ADD;
    use_imm = 1'b0;
    legal   = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == 7'b0000000) begin
          legal = 1'b1;
          case (funct3)
            3'b000:  alu_op = ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: legal  = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          legal  = 1'b1;
          alu_op = ALU_SUB;
        end
      end
      OPC_OP_IMM: begin
        use_imm = 1'b1;
        legal   = 1'b1;
        // Shift immediates carry shamt in imm[4:0]; imm[11:5] must be zero.
        case (funct3)
          3'b000:  alu_op = ALU_ADD;
          3'b010:  alu_op = ALU_SLT;
          3'b100:  alu_op = ALU_XOR;
          3'b110:  alu_op = ALU_OR;
          3'b111:  alu_op = ALU_AND;
          3'b001: begin
            alu_op = ALU_SLL;
            legal  = (funct7 == 7'b0000000);
          end
          3'b101: begin
            alu_op = ALU_SRL;
            legal  = (funct7 == 7'b0000000);
          end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control unit sequencing the RV32I datapath one instruction
// at a time; gates PC, IR and register-file writes.
//
// state     | meaning
// IDLE      | waiting for start
// FETCH     | instruction valid, IR captured at end of cycle
// DECODE    | decode IR, register alu_op/use_imm or trap illegal
// EXECUTE   | ALU runs with registered controls
// WRITEBACK | reg_write + pc_write, retire
// HALT      | stopped until reset
module multicycle_controller
  import cpu_pkg::*;
#(
  parameter int unsigned MAX_INSTRUCTIONS = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  localparam logic [2:0] ST_IDLE      = CS_IDLE;
  localparam logic [2:0] ST_FETCH     = CS_FETCH;
  localparam logic [2:0] ST_DECODE    = CS_DECODE;
  localparam logic [2:0] ST_EXECUTE   = CS_EXECUTE;
  localparam logic [2:0] ST_WRITEBACK = CS_WRITEBACK;
  localparam logic [2:0] ST_HALT      = CS_HALT;

  logic [2:0]  state;
  logic [31:0] ir;
  alu_op_t     alu_op_q;
  logic        use_imm_q;
  logic        illegal_q;
  logic [31:0] retired_count_q;

  alu_op_t     dec_alu_op;
  logic        dec_use_imm;
  logic        dec_legal;
  logic        budget_hit;

  instruction_decoder u_decoder (
    .instruction (ir),
    .alu_op      (dec_alu_op),
    .use_imm     (dec_use_imm),
    .legal       (dec_legal)
  );

  assign budget_hit = (MAX_INSTRUCTIONS != 0) &&
                      ((retired_count_q + 32'd1) == 32'(MAX_INSTRUCTIONS));

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      ir              <= '0;
      alu_op_q        <= ALU_ADD;
      use_imm_q       <= 1'b0;
      illegal_q       <= 1'b0;
      retired_count_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.start) state <= ST_FETCH;
        ST_FETCH: begin
          ir    <= bus.instruction;
          state <= ST_DECODE;
        end
        ST_DECODE: begin
          if (dec_legal) begin
            alu_op_q  <= dec_alu_op;
            use_imm_q <= dec_use_imm;
            state     <= ST_EXECUTE;
          end else begin
            illegal_q <= 1'b1;
            state     <= ST_HALT;
          end
        end
        ST_EXECUTE: state <= ST_WRITEBACK;
        ST_WRITEBACK: begin
          retired_count_q <= retired_count_q + 32'd1;
          state           <= budget_hit ? ST_HALT : ST_FETCH;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strobes are masked by reset so a write in progress never completes.
  assign bus.ir_write      = (state == ST_FETCH) && !reset;
  assign bus.pc_write      = (state == ST_WRITEBACK) && !reset;
  assign bus.reg_write     = (state == ST_WRITEBACK) && !reset;
  assign bus.use_imm       = use_imm_q;
  assign bus.alu_op        = alu_op_q;
  assign bus.busy          = (state == ST_FETCH) || (state == ST_DECODE) ||
                             (state == ST_EXECUTE) || (state == ST_WRITEBACK);
  assign bus.halted        = (state == ST_HALT);
  assign bus.illegal       = illegal_q;
  assign bus.retired_count = retired_count_q;
  assign bus.state_check   = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller: unlimited-budget
// instance for decode/halt/reset behaviour, MAX_INSTRUCTIONS=2 for the budget.
module tb_multicycle_controller;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   pc_cnt0 = 0;
  int   pc_cnt1 = 0;
  int   pc_snap;

  multicycle_controller_if if0 ();
  multicycle_controller_if if1 ();

  multicycle_controller u_dut0 (.clk(clk), .reset(reset), .bus(if0));
  multicycle_controller #(.MAX_INSTRUCTIONS(2)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (if0.pc_write) pc_cnt0++;
    if (if1.pc_write) pc_cnt1++;
  end

  logic [31:0] tv_instr [5] = '{32'h003160b3, 32'h00311093, 32'hfff12093,
                                32'h0ff17093, 32'h003150b3};
  logic [2:0]  tv_op    [5] = '{ALU_OR, ALU_SLL, ALU_SLT, ALU_AND, ALU_SRL};
  logic        tv_imm   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered with dut0 in FETCH; leaves it in the following FETCH.
  task automatic run_legal(input logic [31:0] instr, input logic [2:0] op,
                           input logic imm, input logic [31:0] exp_ret);
    if0.instruction = instr;
    chk("fetch_ir_write", 32'(if0.ir_write), 1);
    tick();
    chk("decode_state", 32'(if0.state_check), 2);
    chk("decode_reg_write", 32'(if0.reg_write), 0);
    tick();
    chk("exec_state", 32'(if0.state_check), 3);
    chk("exec_alu_op", 32'(if0.alu_op), 32'(op));
    chk("exec_use_imm", 32'(if0.use_imm), 32'(imm));
    chk("exec_strobes", {30'd0, if0.reg_write, if0.pc_write}, 0);
    tick();
    chk("wb_state", 32'(if0.state_check), 4);
    chk("wb_alu_op", 32'(if0.alu_op), 32'(op));
    chk("wb_use_imm", 32'(if0.use_imm), 32'(imm));
    chk("wb_strobes", {30'd0, if0.reg_write, if0.pc_write}, 3);
    tick();
    chk("next_fetch", 32'(if0.state_check), 1);
    chk("retired", if0.retired_count, exp_ret);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    if0.start = 1'b0; if0.instruction = '0;
    if1.start = 1'b0; if1.instruction = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_state", 32'(if0.state_check), 0);
    chk("rst_flags", {26'd0, if0.ir_write, if0.pc_write, if0.reg_write,
                      if0.use_imm, if0.busy, if0.halted}, 0);
    chk("rst_illegal", 32'(if0.illegal), 0);
    chk("rst_alu_op", 32'(if0.alu_op), 32'(ALU_ADD));
    chk("rst_retired", if0.retired_count, 0);

    // Budget of two: third instruction never starts, start held high throughout.
    if1.instruction = 32'h005303b3;
    if1.start = 1'b1;
    tick();
    chk("max_fetch", 32'(if1.state_check), 1);
    repeat (8) tick();
    chk("max_state", 32'(if1.state_check), 5);
    chk("max_halted", 32'(if1.halted), 1);
    chk("max_illegal", 32'(if1.illegal), 0);
    chk("max_retired", if1.retired_count, 2);
    chk("max_pc_pulses", 32'(pc_cnt1), 2);
    repeat (3) tick();
    chk("max_stays_halt", 32'(if1.state_check), 5);
    if1.start = 1'b0;

    // Back-to-back legal instructions.
    if0.instruction = 32'h005303b3;
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    chk("start_fetch", 32'(if0.state_check), 1);
    chk("fetch_busy", 32'(if0.busy), 1);
    run_legal(32'h005303b3, ALU_ADD, 1'b0, 1);
    run_legal(32'h00160693, ALU_ADD, 1'b1, 2);
    run_legal(32'h40848533, ALU_SUB, 1'b0, 3);
    for (int i = 0; i < 5; i++) run_legal(tv_instr[i], tv_op[i], tv_imm[i], 32'(4 + i));

    // SRA is rejected.
    if0.instruction = 32'h4084d533;
    pc_snap = pc_cnt0;
    tick();
    chk("sra_decode", 32'(if0.state_check), 2);
    tick();
    chk("sra_halt", 32'(if0.state_check), 5);
    chk("sra_flags", {30'd0, if0.halted, if0.illegal}, 3);
    chk("sra_busy", 32'(if0.busy), 0);
    chk("sra_retired", if0.retired_count, 8);
    if0.start = 1'b1;
    repeat (3) tick();
    if0.start = 1'b0;
    chk("sra_no_pc_write", 32'(pc_cnt0), 32'(pc_snap));
    chk("halt_ignores_start", 32'(if0.state_check), 5);

    // All-zero instruction.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("reset_clears_illegal", 32'(if0.illegal), 0);
    chk("reset_clears_retired", if0.retired_count, 0);
    if0.instruction = 32'h0;
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    tick();
    chk("zero_decode", 32'(if0.state_check), 2);
    tick();
    chk("zero_flags", {30'd0, if0.halted, if0.illegal}, 3);
    chk("zero_retired", if0.retired_count, 0);
    if0.start = 1'b1;
    repeat (2) tick();
    if0.start = 1'b0;
    chk("zero_stays_halt", 32'(if0.state_check), 5);

    // Reset during EXECUTE.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if0.instruction = 32'h005303b3;
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    tick(); tick();
    chk("rstx_exec", 32'(if0.state_check), 3);
    reset = 1'b1;
    #1;
    chk("rstx_strobes", {30'd0, if0.reg_write, if0.pc_write}, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("rstx_idle", 32'(if0.state_check), 0);
    chk("rstx_outputs", {26'd0, if0.ir_write, if0.pc_write, if0.reg_write,
                         if0.use_imm, if0.busy, if0.halted}, 0);

    // Reset during WRITEBACK: masked strobes, no retirement.
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    tick(); tick(); tick();
    chk("rstw_wb", 32'(if0.state_check), 4);
    reset = 1'b1;
    #1;
    chk("rstw_strobes", {30'd0, if0.reg_write, if0.pc_write}, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("rstw_idle", 32'(if0.state_check), 0);
    chk("rstw_retired", if0.retired_count, 0);

    // A fresh start after reset runs normally.
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    chk("restart_fetch", 32'(if0.state_check), 1);
    run_legal(32'h40848533, ALU_SUB, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
